// File: rtl/fetch_decode_pipe.sv
// Two-stage RV64 front end: PC/fetch FSM with one-entry skid buffer feeding an
// IF/ID register, plus decode, immediate generation and a bypassed register file.
module fetch_decode_pipe #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [4:0]      write_addr,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_control_signal,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic            Branch,
    output logic            invOp,
    output logic            invFunc
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2
    } fetch_state_t;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc;
    logic [31:0]     id_instr;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] regs [32];

    logic take_word, to_skid, skid_to_id, id_drain;

    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        take_word  = 1'b0;
        to_skid    = 1'b0;
        skid_to_id = 1'b0;
        id_drain   = 1'b0;
        case (state)
            ST_RESET: state_next = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    if (!id_valid || !stall) begin
                        take_word = 1'b1;
                    end else begin
                        to_skid    = 1'b1;
                        state_next = ST_SKID;
                    end
                end else if (!stall) begin
                    id_drain = 1'b1;
                end
            end
            ST_SKID: begin
                if (!stall) begin
                    skid_to_id = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_RESET;
        endcase
        if (redirect_valid) begin
            state_next = ST_FETCH;
        end
    end

    // Redirect outranks every fetch action, so the datapath checks it before the FSM strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            pc         <= RESET_PC;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= redirect_pc & ~XLEN'(3);
                id_valid <= 1'b0;
            end else begin
                if (take_word) begin
                    id_instr <= imem_rdata;
                    id_pc    <= pc;
                    id_valid <= 1'b1;
                    pc       <= pc + XLEN'(PC_STEP);
                end
                if (to_skid) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= pc;
                    pc         <= pc + XLEN'(PC_STEP);
                end
                if (skid_to_id) begin
                    id_instr <= skid_instr;
                    id_pc    <= skid_pc;
                    id_valid <= 1'b1;
                end
                if (id_drain) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    logic [4:0] rs1, rs2;
    assign rs1        = id_instr[19:15];
    assign rs2        = id_instr[24:20];
    assign write_addr = id_instr[11:7];

    // Write-back bypass lets a same-cycle write reach decode without a bubble.
    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (wb_en && (wb_addr == rs1)) begin
            rd1 = wb_data;
        end
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (wb_en && (wb_addr == rs2)) begin
            rd2 = wb_data;
        end
    end

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];

    always_comb begin
        RegWrite           = 1'b0;
        MemRead            = 1'b0;
        MemtoReg           = 1'b0;
        MemWrite           = 1'b0;
        Branch             = 1'b0;
        alu_control_signal = 4'b0000;
        invOp              = 1'b0;
        invFunc            = 1'b0;
        imm                = '0;
        if (id_valid) begin
            case (opcode)
                7'b0110011: begin
                    RegWrite = 1'b1;
                    if (funct7 == 7'b0000000 && funct3 == 3'b000)      alu_control_signal = 4'b0010;
                    else if (funct7 == 7'b0100000 && funct3 == 3'b000) alu_control_signal = 4'b0110;
                    else if (funct7 == 7'b0000000 && funct3 == 3'b111) alu_control_signal = 4'b0000;
                    else if (funct7 == 7'b0000000 && funct3 == 3'b110) alu_control_signal = 4'b0001;
                    else                                               invFunc = 1'b1;
                end
                7'b0010011: begin
                    RegWrite = 1'b1;
                    imm      = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
                    case (funct3)
                        3'b000:  alu_control_signal = 4'b0010;
                        3'b111:  alu_control_signal = 4'b0000;
                        3'b110:  alu_control_signal = 4'b0001;
                        default: invFunc = 1'b1;
                    endcase
                end
                7'b0000011: begin
                    RegWrite           = 1'b1;
                    MemRead            = 1'b1;
                    MemtoReg           = 1'b1;
                    alu_control_signal = 4'b0010;
                    imm                = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
                end
                7'b0100011: begin
                    MemWrite           = 1'b1;
                    alu_control_signal = 4'b0010;
                    imm                = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
                end
                7'b1100011: begin
                    Branch             = 1'b1;
                    alu_control_signal = 4'b0110;
                    imm                = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                                          id_instr[30:25], id_instr[11:8], 1'b0};
                end
                default: invOp = 1'b1;
            endcase
            // An unsupported instruction must not produce side effects downstream.
            if (invOp || invFunc) begin
                RegWrite           = 1'b0;
                MemRead            = 1'b0;
                MemtoReg           = 1'b0;
                MemWrite           = 1'b0;
                Branch             = 1'b0;
                alu_control_signal = 4'b1111;
                imm                = '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed self-checking bench for fetch_decode_pipe: fetch streaming, stall/skid,
// write-back bypass, redirect, decode table and reset while in the skid state.
module tb_fetch_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] rd1, rd2;
    logic [4:0]  write_addr;
    logic [63:0] imm;
    logic [3:0]  alu_control_signal;
    logic        RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_decode_pipe #(.XLEN(64), .RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .rd1(rd1), .rd2(rd2),
        .write_addr(write_addr), .imm(imm), .alu_control_signal(alu_control_signal),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .Branch(Branch), .invOp(invOp), .invFunc(invFunc)
    );

    localparam logic [31:0] ADD_X3 = 32'h002081B3;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
        redirect_pc = '0; stall = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idv: got %b expected 0", id_valid); end
        checks++; if ({RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc} !== 7'b0)
            begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc}); end
        checks++; if (alu_control_signal !== 4'b0000) begin errors++; $display("[TB] FAIL reset_alu: got %b expected 0000", alu_control_signal); end
        checks++; if ({imm, rd1, rd2} !== '0) begin errors++; $display("[TB] FAIL reset_data: imm %h rd1 %h rd2 %h expected 0", imm, rd1, rd2); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL first_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_fetch_stream();
        imem_valid = 1'b1; imem_rdata = ADD_X3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_idv%0d: got %b expected 1", i, id_valid); end
            checks++; if (id_pc !== 64'(i * 4)) begin errors++; $display("[TB] FAIL stream_pc%0d: got %h expected %h", i, id_pc, 64'(i * 4)); end
            checks++; if (alu_control_signal !== 4'b0010) begin errors++; $display("[TB] FAIL stream_alu%0d: got %b expected 0010", i, alu_control_signal); end
            checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL stream_rw%0d: got %b expected 1", i, RegWrite); end
            checks++; if (write_addr !== 5'd3) begin errors++; $display("[TB] FAIL stream_rd%0d: got %0d expected 3", i, write_addr); end
        end
        imem_valid = 1'b0;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", id_valid); end
        checks++; if (imem_addr !== 64'd12) begin errors++; $display("[TB] FAIL stream_addr: got %h expected c", imem_addr); end
    endtask

    task automatic test_stall_skid();
        imem_valid = 1'b1; imem_rdata = ADD_X3; stall = 1'b0;
        step();
        checks++; if (id_pc !== 64'd12) begin errors++; $display("[TB] FAIL stall_load: got %h expected c", id_pc); end
        stall = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL skid_req1: got %b expected 0", imem_req); end
        checks++; if (id_pc !== 64'd12) begin errors++; $display("[TB] FAIL skid_hold1: got %h expected c", id_pc); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL skid_req2: got %b expected 0", imem_req); end
        checks++; if ({id_valid, id_pc} !== {1'b1, 64'd12}) begin errors++; $display("[TB] FAIL skid_hold2: got %b/%h expected 1/c", id_valid, id_pc); end
        checks++; if (imem_addr !== 64'd20) begin errors++; $display("[TB] FAIL skid_addr: got %h expected 14", imem_addr); end
        stall = 1'b0;
        step();
        checks++; if (id_pc !== 64'd16) begin errors++; $display("[TB] FAIL skid_release: got %h expected 10", id_pc); end
        checks++; if ({imem_req, imem_addr} !== {1'b1, 64'd20}) begin errors++; $display("[TB] FAIL skid_resume: got %b/%h expected 1/14", imem_req, imem_addr); end
        step();
        checks++; if (id_pc !== 64'd20) begin errors++; $display("[TB] FAIL skid_next: got %h expected 14", id_pc); end
        checks++; if (imem_addr !== 64'd24) begin errors++; $display("[TB] FAIL skid_next_addr: got %h expected 18", imem_addr); end
        imem_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        imem_valid = 1'b1; imem_rdata = ADD_X3; stall = 1'b0;
        step();
        imem_valid = 1'b0; stall = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'hDEAD;
        #1;
        checks++; if (rd1 !== 64'hDEAD) begin errors++; $display("[TB] FAIL bypass_rd1: got %h expected dead", rd1); end
        checks++; if (rd2 !== 64'h0) begin errors++; $display("[TB] FAIL bypass_rd2: got %h expected 0", rd2); end
        step();
        wb_addr = 5'd2; wb_data = 64'h1234;
        step();
        wb_en = 1'b0;
        #1;
        checks++; if (rd1 !== 64'hDEAD) begin errors++; $display("[TB] FAIL regfile_rd1: got %h expected dead", rd1); end
        checks++; if (rd2 !== 64'h1234) begin errors++; $display("[TB] FAIL regfile_rd2: got %h expected 1234", rd2); end
        stall = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h00500093;
        step();
        imem_valid = 1'b0; stall = 1'b1;
        checks++; if ({alu_control_signal, RegWrite, imm} !== {4'b0010, 1'b1, 64'd5})
            begin errors++; $display("[TB] FAIL addi_decode: got %b/%b/%h expected 0010/1/5", alu_control_signal, RegWrite, imm); end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hBEEF;
        #1;
        checks++; if (rd1 !== 64'h0) begin errors++; $display("[TB] FAIL x0_bypass: got %h expected 0", rd1); end
        step();
        wb_en = 1'b0;
        #1;
        checks++; if (rd1 !== 64'h0) begin errors++; $display("[TB] FAIL x0_write: got %h expected 0", rd1); end
        stall = 1'b0;
        step();
    endtask

    task automatic test_redirect();
        imem_valid = 1'b1; imem_rdata = ADD_X3; redirect_valid = 1'b1; redirect_pc = 64'h103;
        step();
        redirect_valid = 1'b0;
        imem_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %b expected 0", id_valid); end
        checks++; if (imem_addr !== 64'h100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 100", imem_addr); end
        imem_valid = 1'b1;
        step();
        checks++; if ({id_valid, id_pc} !== {1'b1, 64'h100}) begin errors++; $display("[TB] FAIL redir_fetch: got %b/%h expected 1/100", id_valid, id_pc); end
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; imem_valid = 1'b0;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pre: got %h expected fffffffffffffffc", imem_addr); end
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 0", imem_addr); end
        checks++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_idpc: got %h expected fffffffffffffffc", id_pc); end
        step();
    endtask

    task automatic test_decode();
        // instr, alu, {RegWrite,MemRead,MemtoReg,MemWrite,Branch}, imm, {invOp,invFunc}
        logic [31:0] instr [6];
        logic [3:0]  alu   [6];
        logic [4:0]  ctrl  [6];
        logic [63:0] eimm  [6];
        logic [1:0]  inv   [6];
        instr[0] = 32'hFFC12283; alu[0] = 4'b0010; ctrl[0] = 5'b11100; eimm[0] = 64'hFFFF_FFFF_FFFF_FFFC; inv[0] = 2'b00;
        instr[1] = 32'h0000007F; alu[1] = 4'b1111; ctrl[1] = 5'b00000; eimm[1] = 64'h0;                   inv[1] = 2'b10;
        instr[2] = 32'h40208133; alu[2] = 4'b0110; ctrl[2] = 5'b10000; eimm[2] = 64'h0;                   inv[2] = 2'b00;
        instr[3] = 32'h0020A423; alu[3] = 4'b0010; ctrl[3] = 5'b00010; eimm[3] = 64'h8;                   inv[3] = 2'b00;
        instr[4] = 32'hFE208CE3; alu[4] = 4'b0110; ctrl[4] = 5'b00001; eimm[4] = 64'hFFFF_FFFF_FFFF_FFF8; inv[4] = 2'b00;
        instr[5] = 32'h00209133; alu[5] = 4'b1111; ctrl[5] = 5'b00000; eimm[5] = 64'h0;                   inv[5] = 2'b01;
        imem_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem_rdata = instr[i];
            step();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec%0d_idv: got %b expected 1", i, id_valid); end
            checks++; if (alu_control_signal !== alu[i]) begin errors++; $display("[TB] FAIL dec%0d_alu: got %b expected %b", i, alu_control_signal, alu[i]); end
            checks++; if ({RegWrite, MemRead, MemtoReg, MemWrite, Branch} !== ctrl[i])
                begin errors++; $display("[TB] FAIL dec%0d_ctrl: got %b expected %b", i, {RegWrite, MemRead, MemtoReg, MemWrite, Branch}, ctrl[i]); end
            checks++; if (imm !== eimm[i]) begin errors++; $display("[TB] FAIL dec%0d_imm: got %h expected %h", i, imm, eimm[i]); end
            checks++; if ({invOp, invFunc} !== inv[i]) begin errors++; $display("[TB] FAIL dec%0d_inv: got %b expected %b", i, {invOp, invFunc}, inv[i]); end
        end
        checks++; if (write_addr !== 5'd2) begin errors++; $display("[TB] FAIL dec_rd: got %0d expected 2", write_addr); end
        imem_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_skid();
        imem_valid = 1'b1; imem_rdata = ADD_X3; stall = 1'b0;
        step();
        stall = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rskid_enter: got %b expected 0", imem_req); end
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h200;
        step();
        checks++; if ({imem_req, id_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rskid_req: got %b expected 00", {imem_req, id_valid}); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL rskid_pc: got %h expected 0", imem_addr); end
        checks++; if ({RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc, alu_control_signal} !== 11'b0)
            begin errors++; $display("[TB] FAIL rskid_ctrl: got %b expected 0", {RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc, alu_control_signal}); end
        checks++; if ({imm, rd1, rd2} !== '0) begin errors++; $display("[TB] FAIL rskid_data: imm %h rd1 %h rd2 %h expected 0", imm, rd1, rd2); end
        rst_n = 1'b1; redirect_valid = 1'b0; imem_valid = 1'b0; stall = 1'b0;
        step();
        checks++; if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin errors++; $display("[TB] FAIL rskid_restart: got %b/%h expected 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_stall_skid();
        test_bypass();
        test_redirect();
        test_decode();
        test_reset_in_skid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
# fetch_decode_pipe

Parametrised two-stage front end for the RV64 datapath: a PC register and fetch FSM drive an instruction-memory request/valid handshake, and fetched words land in an IF/ID pipeline register. The decode stage produces the existing control-signal set (RegWrite, MemRead, MemtoReg, MemWrite, Branch, alu_control_signal) plus an XLEN-wide register file, write-back bypass, immediate generation, stall, and branch redirect/flush. Downstream execute/memory stages consume its ID outputs.

## Interface
- XLEN, 64, register and PC width (32 or 64)
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per fetched instruction
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- imem_req  out  1  fetch request; imem_addr held stable while high
- imem_addr  out  XLEN  fetch address (current PC)
- imem_valid  in  1  imem_rdata valid for imem_addr this cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  branch taken / flush request
- redirect_pc  in  XLEN  new PC; bits [1:0] forced to 0
- stall  in  1  downstream cannot accept ID contents; hold them
- wb_en, wb_addr, wb_data  in  1/5/XLEN  register write-back port
- id_valid  out  1  ID contents valid
- id_pc  out  XLEN  PC of ID instruction
- rd1, rd2  out  XLEN  rs1/rs2 read data (combinational from ID instruction)
- write_addr  out  5  rd field
- imm  out  XLEN  sign-extended immediate
- alu_control_signal  out  4  ALU op
- RegWrite, MemRead, MemtoReg, MemWrite, Branch  out  1 each  control
- invOp, invFunc  out  1 each  unsupported opcode / funct

## Operation
- Fetch FSM states: RESET → FETCH ⇄ SKID.
- FETCH: imem_req=1, imem_addr=PC. On imem_valid: if ID free (id_valid=0 or stall=0) → word to IF/ID, PC+=PC_STEP, stay FETCH; else → word to 1-entry skid, PC+=PC_STEP, go SKID.
- SKID: imem_req=0. When stall=0 → skid to IF/ID, return FETCH.
- ID empties (id_valid→0) when stall=0 and no new word arrives.
- Redirect (priority over all except reset): next edge PC=redirect_pc&~3, id_valid=0, skid cleared, state FETCH; concurrent imem_valid discarded.
- Decode (ID register only): 0110011 R: add(f3 000,f7 0000000)=0010, sub(000,0100000)=0110, and(111)=0000, or(110)=0001, RegWrite=1. 0010011 I: addi 0010, andi 0000, ori 0001, RegWrite=1. 0000011 load: 0010, RegWrite, MemRead, MemtoReg. 0100011 store: 0010, MemWrite. 1100011 branch: 0110, Branch.
- Unknown opcode → invOp=1; unknown funct → invFunc=1; either → all control 0, alu 1111; id_valid stays 1.
- imm: I/load from [31:20], S [31:25|11:7], B [31|7|30:25|11:8|0], sign-extended to XLEN; R/invalid → 0.
- Regfile 32×XLEN, x0 reads 0, writes to x0 ignored. Write on clk when wb_en. Bypass: wb_en && wb_addr==rs && rs!=0 → rd = wb_data same cycle.

## Timing
- Reset: PC=RESET_PC, regs=0, state RESET; all outputs 0 (imem_req, id_valid, controls, rd1/rd2, imm, inv flags); alu_control_signal=0000.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- imem_valid at edge N → id_valid=1 with decoded outputs after edge N; one instruction/cycle sustained with imem_valid every cycle.
- Stall: all ID outputs bit-stable except rd1/rd2, which track write-back.
- Reset mid-operation wins over redirect, stall, imem_valid.
- PC wraps modulo 2^XLEN without error.

## Test plan
- Reset then imem_valid every cycle with add x3,x1,x2 (0x002081B3) at 0, 4, 8 → id_pc 0,4,8 consecutive cycles, alu 0010, RegWrite=1, write_addr=3.
- stall=1 two cycles while id_valid, imem_valid continuous → one word in skid, imem_req drops, ID held; stall=0 → skid word to ID, fetch resumes at PC+8, no loss or duplication.
- wb_en=1, wb_addr=1, wb_data=0xDEAD with ID rs1=1 → rd1=0xDEAD same cycle; wb_addr=0 → rd1 stays 0.
- redirect_valid with redirect_pc=0x103 coincident with imem_valid → that word dropped, id_valid=0 next cycle, imem_addr=0x100.
- lw x5,-4(x2) (0xFFC12283) → imm=0xFFFF_FFFF_FFFF_FFFC, MemRead/MemtoReg/RegWrite=1; opcode 0x7F → invOp=1, controls 0, alu 1111.
- Assert rst_n=0 in SKID → next edge all outputs 0, PC=RESET_PC.
